// File: rtl/forward_hazard_unit_pkg.sv
// Shared forwarding-select encodings and hazard tag-entry type for the
// hazard unit and the EX-stage operand muxes.
package forward_hazard_unit_pkg;

  localparam int TAG_AW = 8;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic [TAG_AW-1:0] dest;
  } tag_t;

  // Register 0 is hard-wired, so a producer writing it never matches.
  function automatic logic tag_match(input tag_t e, input logic [TAG_AW-1:0] src);
    return e.valid & e.regwrite & (e.dest != '0) & (e.dest == src);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_tag_stage.sv
// One entry of the EX/MEM/WB tag pipeline: async-reset register whose
// bubble input loads an invalid entry.
import forward_hazard_unit_pkg::*;

module hazard_tag_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic bubble,
  input  tag_t d,
  output tag_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard detection: tracks in-flight destinations
// and produces registered EX operand selects plus the ID stall.
import forward_hazard_unit_pkg::*;

module forward_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_valid_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  function automatic logic [TAG_AW-1:0] widen(input logic [REG_AW-1:0] idx);
    widen = '0;
    widen[REG_AW-1:0] = idx;
  endfunction

  function automatic logic [1:0] sel_for(input tag_t ex, input tag_t mem,
                                         input logic [TAG_AW-1:0] src);
    if (tag_match(ex, src))       return FWD_EXMEM;
    else if (tag_match(mem, src)) return FWD_MEMWB;
    else                          return FWD_RF;
  endfunction

  tag_t              tag_id, tag_ex, tag_mem, tag_wb;
  logic [TAG_AW-1:0] rs_w, rt_w;
  logic              ex_bubble, kill;
  logic [1:0]        fwd_a_nxt, fwd_b_nxt;
  logic              unused_tags;

  assign rs_w = widen(id_rs_i);
  assign rt_w = widen(id_rt_i);

  // ID stage: decode the incoming instruction against in-flight producers
  assign stall_o = id_valid_i & tag_ex.memread &
                   (tag_match(tag_ex, rs_w) | tag_match(tag_ex, rt_w)) & ~flush_i;

  assign ex_bubble = stall_o | flush_i;
  assign kill      = ex_bubble | ~id_valid_i;

  always_comb begin
    tag_id          = '0;
    tag_id.valid    = id_valid_i;
    tag_id.regwrite = id_regwrite_i;
    tag_id.memread  = id_memread_i;
    tag_id.dest     = widen(id_rd_i);
  end

  always_comb begin
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    if (!kill) begin
      fwd_a_nxt = sel_for(tag_ex, tag_mem, rs_w);
      fwd_b_nxt = sel_for(tag_ex, tag_mem, rt_w);
    end
  end

  // ID -> EX -> MEM -> WB tag pipeline; stalls only bubble EX
  hazard_tag_stage u_ex (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .bubble (ex_bubble),
    .d      (tag_id),
    .q      (tag_ex)
  );

  hazard_tag_stage u_mem (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .bubble (1'b0),
    .d      (tag_ex),
    .q      (tag_mem)
  );

  hazard_tag_stage u_wb (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .bubble (1'b0),
    .d      (tag_mem),
    .q      (tag_wb)
  );

  // WB is retired state kept for observability; nothing forwards from it.
  assign unused_tags = ^{tag_wb, tag_mem.memread};

  // EX stage: selects become valid while the decoded instruction is in EX
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fwd_a_o <= FWD_RF;
      fwd_b_o <= FWD_RF;
    end else begin
      fwd_a_o <= fwd_a_nxt;
      fwd_b_o <= fwd_b_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed checks of forwarding selects, load-use stall, flush, reset and
// stall-counter saturation.
module tb_forward_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_regwrite, id_memread, id_valid, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
  logic [3:0] stall_cnt;

  int   checks = 0;
  int   errors = 0;
  logic st;

  forward_hazard_unit #(.REG_AW(5), .CNT_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .id_valid_i    (id_valid),
    .flush_i       (flush),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .stall_o       (stall),
    .stall_cnt_o   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one ID instruction, sample the stall, then let it enter EX.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic v, input logic fl);
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_regwrite = rw; id_memread = mr; id_valid = v; flush = fl;
    #1 st = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic nops();
    for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_valid = 1'b0; flush = 1'b0;
    #12;
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // EX->EX forward of $3 to rs
    nops();
    step(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd3, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("exfwd_stall", st, 0);
    chk("exfwd_a", fwd_a, 1);
    chk("exfwd_b", fwd_b, 0);

    // MEM->EX forward of $5 to rt across one unrelated instruction
    nops();
    step(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd1, 5'd5, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("memfwd_a", fwd_a, 0);
    chk("memfwd_b", fwd_b, 2);

    // Load-use: one stall cycle, bubble, then MEM forward
    nops();
    step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(5'd4, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lu_stall", st, 1);
    chk("lu_bub_a", fwd_a, 0);
    chk("lu_bub_b", fwd_b, 0);
    chk("lu_cnt1", stall_cnt, 1);
    step(5'd4, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lu_nostall2", st, 0);
    chk("lu_fwd_a", fwd_a, 2);
    chk("lu_fwd_b", fwd_b, 0);
    chk("lu_cnt_hold", stall_cnt, 1);

    // Two writers of $7: younger (EX) wins on both operands
    nops();
    step(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd7, 5'd7, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("young_a", fwd_a, 1);
    chk("young_b", fwd_b, 1);

    // $0 is never forwarded nor a load-use source
    nops();
    step(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("r0_stall", st, 0);
    chk("r0_a", fwd_a, 0);
    chk("r0_b", fwd_b, 0);

    // Flush overrides load-use stall and bubbles EX
    nops();
    step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(5'd4, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("fl_stall", st, 0);
    chk("fl_a", fwd_a, 0);
    chk("fl_b", fwd_b, 0);
    step(5'd13, 5'd4, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("fl_killed_a", fwd_a, 0);
    chk("fl_load_mem_b", fwd_b, 2);
    chk("fl_cnt", stall_cnt, 1);

    // Reset asserted mid-stall acts without a clock edge
    nops();
    step(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd6, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pre_fwd_a", fwd_a, 1);
    @(negedge clk);
    id_rs = 5'd4; id_rt = 5'd0; id_rd = 5'd15;
    id_regwrite = 1'b1; id_memread = 1'b0; id_valid = 1'b1; flush = 1'b0;
    #1;
    chk("mid_stall", stall, 1);
    chk("mid_cnt", stall_cnt, 1);
    rst = 1'b0;
    #1;
    chk("mrst_stall", stall, 0);
    chk("mrst_fwd_a", fwd_a, 0);
    chk("mrst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    step(5'd4, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_stall", st, 0);
    chk("post_fwd_a", fwd_a, 0);
    chk("post_cnt", stall_cnt, 0);

    // Counter saturation with a 4-bit counter
    for (int i = 0; i < 15; i++) begin
      step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
      step(5'd4, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("sat_stall", st, 1);
    end
    chk("sat_cnt15", stall_cnt, 15);
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
      step(5'd4, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    chk("sat_hold", stall_cnt, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have id_rs_i and id_rt_i, input, REG_AW each, source indices of the instruction in ID.
REQ-006 SHALL have id_rd_i, input, REG_AW, destination of the ID instruction after RegDst selection.
REQ-007 SHALL have id_regwrite_i, id_memread_i and id_valid_i, input, 1 each, ID instruction control bits.
REQ-008 SHALL have flush_i, input, 1, branch-taken kill of the ID instruction.
REQ-009 SHALL have fwd_a_o and fwd_b_o, output, 2 each, registered selects for the EX-stage 3-to-1 operand muxes.
REQ-010 SHALL have stall_o, output, 1, hold PC and IF/ID and bubble ID/EX.
REQ-011 SHALL have stall_cnt_o, output, CNT_W, saturating count of stall cycles.

Function
REQ-012 SHALL keep an internal 3-entry tag pipeline (EX, MEM, WB), each entry holding {valid, regwrite, memread, dest}, advancing every cycle.
REQ-013 SHALL define an ID-side match against entry E as: E.valid & E.regwrite & E.dest != 0 & E.dest == source.
REQ-014 SHALL drive stall_o combinationally = id_valid_i & EX.memread & (match(EX, rs) | match(EX, rt)) & ~flush_i.
REQ-015 SHALL load EX with a bubble (valid=0) when stall_o or flush_i is 1; otherwise it SHALL load EX with {id_valid_i, id_regwrite_i, id_memread_i, id_rd_i}.
REQ-016 SHALL always shift EX into MEM and MEM into WB; stall SHALL NOT hold MEM or WB.
REQ-017 SHALL compute each next select at ID and register it, so it is valid while that instruction is in EX (1-cycle latency): 1 (EX/MEM result) if match(EX, src); else 2 (MEM/WB writeback) if match(MEM, src); else 0 (register-file operand).
REQ-018 SHALL give the younger producer (EX entry) priority when both EX and MEM match.
REQ-019 SHALL register selects of 0 whenever EX is loaded with a bubble.
REQ-020 SHALL never output select value 3.
REQ-021 SHALL never forward register 0, even if a producer writes it.
REQ-022 SHALL, after a 1-cycle load-use stall, see the load in MEM and register select 2 for the dependent, with no second stall.
REQ-023 SHALL increment stall_cnt_o on each cycle stall_o=1 and hold it at all-ones on overflow.
REQ-024 SHALL give flush_i priority over stall when both would apply in the same cycle.

Reset
REQ-025 SHALL, on rst_i=0, immediately and independently of the clock, clear all tag entries to valid=0, fwd_a_o/fwd_b_o to 0 and stall_cnt_o to 0.
REQ-026 SHALL drive stall_o to 0 during reset, as a consequence of the EX entry being invalid.
REQ-027 SHALL let an assertion of rst_i mid-stall discard the stall; the first post-reset ID instruction SHALL see no producers.

Structure
REQ-028 SHALL place the select encoding constants (FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2) and the tag-entry typedef in a shared package, for reuse by the EX-stage mux instantiation.
REQ-029 SHALL implement each tag register as sub-module hazard_tag_stage (async-reset register with bubble input), instantiated three times.

Verification
REQ-030 SHALL cover: add $3 then sub using rs=$3 on the next instruction -> fwd_a_o=1 in the dependent's EX cycle, stall_o=0.
REQ-031 SHALL cover: producer $5, one unrelated instruction, then consumer rt=$5 -> fwd_b_o=2.
REQ-032 SHALL cover: lw $4 then add rs=$4 -> stall_o=1 for exactly 1 cycle, an EX bubble with selects 0, then fwd_a_o=2, and stall_cnt_o=1.
REQ-033 SHALL cover: two consecutive writers of $7, then consumer rs=rt=$7 -> fwd_a_o=fwd_b_o=1 (younger wins).
REQ-034 SHALL cover: writer of $0, then consumer of $0 -> selects 0; lw-use hazard with flush_i=1 -> stall_o=0, EX bubble.
REQ-035 SHALL cover: rst_i low mid-stall -> stall_o=0, outputs 0 without a clock edge; forcing the counter to all-ones with further stalls -> it stays all-ones.
